// File: rtl/fan_run_ctrl_if.sv
// Fan controller boundary: timer status and button in, motor PWM and LED status out.
// The master side is the timer / board top level. The slave side is fan_run_ctrl.
interface fan_run_ctrl_if;
   logic        btn_speed;
   logic        timer_start;
   logic        start_stop;
   logic [15:0] timer_value;
   logic        pwm_out;
   logic [3:0]  speed_led;
   logic        run;
   logic        warn;

   modport master (
      output btn_speed, timer_start, start_stop, timer_value,
      input  pwm_out, speed_led, run, warn
   );

   modport slave (
      input  btn_speed, timer_start, start_stop, timer_value,
      output pwm_out, speed_led, run, warn
   );
endinterface

// File: rtl/fan_run_ctrl.sv
// Fan run controller: speed selection FSM, soft-start duty ramp, motor PWM and timeout handling.
// It also blinks a warning during the last minutes of an armed timer.
module fan_run_ctrl #(
   parameter int PWM_STEP_DIV = 100,
   parameter int RAMP_DIV     = 1000000,
   parameter int BLINK_DIV    = 50000000,
   parameter int DUTY_LOW     = 30,
   parameter int DUTY_MID     = 60,
   parameter int DUTY_HIGH    = 100
) (
   input  logic         clk,
   input  logic         reset_p,
   fan_run_ctrl_if.slave bus
);

   localparam int PRE_W   = (PWM_STEP_DIV > 1) ? $clog2(PWM_STEP_DIV) : 1;
   localparam int RAMP_W  = (RAMP_DIV > 1)     ? $clog2(RAMP_DIV)     : 1;
   localparam int BLINK_W = (BLINK_DIV > 1)    ? $clog2(BLINK_DIV)    : 1;

   // One-hot encoding so the state register drives speed_led directly.
   typedef enum logic [3:0] {
      S_OFF  = 4'b0001,
      S_LOW  = 4'b0010,
      S_MID  = 4'b0100,
      S_HIGH = 4'b1000
   } state_t;

   state_t               r_state;
   logic                 r_btn_d;
   logic                 r_ss_d;
   logic [6:0]           r_duty;
   logic [RAMP_W-1:0]    r_ramp_cnt;
   logic [PRE_W-1:0]     r_pwm_pre;
   logic [6:0]           r_pwm_cnt;
   logic                 r_pwm_out;
   logic                 r_run;
   logic                 r_warn;
   logic                 r_warn_act;
   logic [BLINK_W-1:0]   r_blink_cnt;

   logic                 w_btn_rise;
   logic                 w_lock;
   logic                 w_timeout;
   logic                 w_ramp_tick;
   logic                 w_pwm_tick;
   logic                 w_warn_cond;
   logic [6:0]           w_target;

   function automatic logic [6:0] f_target(input state_t s);
      case (s)
         S_OFF:   f_target = 7'd0;
         S_LOW:   f_target = 7'(DUTY_LOW);
         S_MID:   f_target = 7'(DUTY_MID);
         S_HIGH:  f_target = 7'(DUTY_HIGH);
         default: f_target = 7'd0;
      endcase
   endfunction

   assign w_btn_rise  = bus.btn_speed & ~r_btn_d;
   assign w_lock      = bus.timer_start & bus.start_stop;
   assign w_timeout   = w_lock & ~r_ss_d;
   assign w_ramp_tick = (r_ramp_cnt == RAMP_W'(RAMP_DIV - 1));
   assign w_pwm_tick  = (r_pwm_pre == PRE_W'(PWM_STEP_DIV - 1));
   assign w_warn_cond = bus.timer_start & ~bus.start_stop &
                        (bus.timer_value[15:4] == 12'd0) & (bus.timer_value != 16'd0);
   assign w_target    = f_target(r_state);

   // Speed FSM; an expired armed timer holds it at OFF and beats any button edge.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         r_state <= S_OFF;
         r_btn_d <= 1'b0;
         r_ss_d  <= 1'b0;
      end else begin
         r_btn_d <= bus.btn_speed;
         r_ss_d  <= bus.start_stop;
         if (w_lock) begin
            r_state <= S_OFF;
         end else if (w_btn_rise) begin
            case (r_state)
               S_OFF:   r_state <= S_LOW;
               S_LOW:   r_state <= S_MID;
               S_MID:   r_state <= S_HIGH;
               S_HIGH:  r_state <= S_OFF;
               default: r_state <= S_OFF;
            endcase
         end else begin
            r_state <= r_state;
         end
      end
   end

   // Soft-start ramp; a timeout drops the duty at once and restarts the ramp phase.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         r_ramp_cnt <= '0;
         r_duty     <= 7'd0;
      end else if (w_timeout) begin
         r_ramp_cnt <= '0;
         r_duty     <= 7'd0;
      end else begin
         r_ramp_cnt <= w_ramp_tick ? '0 : r_ramp_cnt + RAMP_W'(1);
         if (w_ramp_tick && (r_duty < w_target)) begin
            r_duty <= r_duty + 7'd1;
         end else if (w_ramp_tick && (r_duty > w_target)) begin
            r_duty <= r_duty - 7'd1;
         end else begin
            r_duty <= r_duty;
         end
      end
   end

   // PWM step counter and registered compare; a timeout also blanks the outputs on the same edge.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         r_pwm_pre <= '0;
         r_pwm_cnt <= 7'd0;
         r_pwm_out <= 1'b0;
         r_run     <= 1'b0;
      end else begin
         r_pwm_pre <= w_pwm_tick ? '0 : r_pwm_pre + PRE_W'(1);
         if (w_pwm_tick) begin
            r_pwm_cnt <= (r_pwm_cnt == 7'd99) ? 7'd0 : r_pwm_cnt + 7'd1;
         end else begin
            r_pwm_cnt <= r_pwm_cnt;
         end
         if (w_timeout) begin
            r_pwm_out <= 1'b0;
            r_run     <= 1'b0;
         end else begin
            r_pwm_out <= (r_pwm_cnt < r_duty);
            r_run     <= (r_duty != 7'd0);
         end
      end
   end

   // Warning blink: starts high on the first qualifying cycle and toggles every BLINK_DIV cycles.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         r_warn      <= 1'b0;
         r_warn_act  <= 1'b0;
         r_blink_cnt <= '0;
      end else if (!w_warn_cond) begin
         r_warn      <= 1'b0;
         r_warn_act  <= 1'b0;
         r_blink_cnt <= '0;
      end else if (!r_warn_act) begin
         r_warn      <= 1'b1;
         r_warn_act  <= 1'b1;
         r_blink_cnt <= '0;
      end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
         r_warn      <= ~r_warn;
         r_warn_act  <= 1'b1;
         r_blink_cnt <= '0;
      end else begin
         r_warn      <= r_warn;
         r_warn_act  <= 1'b1;
         r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
      end
   end

   assign bus.pwm_out   = r_pwm_out;
   assign bus.speed_led = r_state;
   assign bus.run       = r_run;
   assign bus.warn      = r_warn;

endmodule

// File: tb/tb_fan_run_ctrl.sv
// Bench for fan_run_ctrl: directed scenarios plus a random phase, checked every cycle
// against an elapsed-time reference model of speed, duty, PWM and warn behaviour.
module tb_fan_run_ctrl;

   localparam int RAMP  = 4;
   localparam int BLINK = 8;

   logic clk = 1'b0;
   logic reset_p;
   fan_run_ctrl_if bus();

   fan_run_ctrl #(
      .PWM_STEP_DIV(1), .RAMP_DIV(RAMP), .BLINK_DIV(BLINK),
      .DUTY_LOW(30), .DUTY_MID(60), .DUTY_HIGH(100)
   ) dut (
      .clk(clk),
      .reset_p(reset_p),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: speed index 0..3, duty in percent, elapsed-cycle counters.
   int tgt [4] = '{0, 30, 60, 100};
   int m_idx, m_duty, m_ramp_age, m_cyc, m_warn_n;
   bit m_pwm, m_run, m_warn, m_bprev, m_sprev;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_idx = 0; m_duty = 0; m_ramp_age = 0; m_cyc = 0; m_warn_n = -1;
      m_pwm = 1'b0; m_run = 1'b0; m_warn = 1'b0; m_bprev = 1'b0; m_sprev = 1'b0;
   endtask

   task automatic model_clk();
      bit to, lock, brise, cond;
      if (reset_p) begin
         model_reset();
      end else begin
         lock  = bus.timer_start && bus.start_stop;
         to    = lock && !m_sprev;
         brise = bus.btn_speed && !m_bprev;
         cond  = bus.timer_start && !bus.start_stop && (bus.timer_value < 16'h0010) &&
                 (bus.timer_value != 16'h0000);
         m_pwm = ((m_cyc % 100) < m_duty);
         m_run = (m_duty != 0);
         m_cyc++;
         if (to) begin
            m_pwm = 1'b0; m_run = 1'b0; m_duty = 0; m_ramp_age = 0;
         end else begin
            if ((m_ramp_age % RAMP) == RAMP - 1) begin
               if (m_duty < tgt[m_idx]) m_duty++;
               else if (m_duty > tgt[m_idx]) m_duty--;
            end
            m_ramp_age++;
         end
         if (lock) m_idx = 0;
         else if (brise) m_idx = (m_idx + 1) % 4;
         if (!cond) begin
            m_warn_n = -1; m_warn = 1'b0;
         end else begin
            m_warn_n++;
            m_warn = (((m_warn_n / BLINK) % 2) == 0);
         end
         m_bprev = bus.btn_speed;
         m_sprev = bus.start_stop;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_clk();
      #1;
      check("led",  bus.speed_led, 32'(4'b0001 << m_idx));
      check("pwm",  bus.pwm_out,   m_pwm);
      check("run",  bus.run,       m_run);
      check("warn", bus.warn,      m_warn);
   endtask

   task automatic press();
      bus.btn_speed = 1'b1; tick();
      bus.btn_speed = 1'b0; tick();
   endtask

   task automatic wait_duty(int v, int lim);
      for (int i = 0; i < lim && m_duty != v; i++) tick();
      if (m_duty != v) begin
         n_cmp++; n_bad++;
         $error("FAIL wait_duty observed=%0d expected=%0d", m_duty, v);
      end
   endtask

   initial begin
      int hi;
      logic [15:0] vals [6] = '{16'h0000, 16'h0005, 16'h0009, 16'h0010, 16'h0130, 16'h0001};
      model_reset();
      reset_p = 1'b1;
      bus.btn_speed = 1'b0; bus.timer_start = 1'b0; bus.start_stop = 1'b0;
      bus.timer_value = 16'h0000;
      tick(); tick();
      check("rst_led", bus.speed_led, 4'b0001);
      check("rst_run", bus.run, 1'b0);
      reset_p = 1'b0;
      tick();

      // 1: three presses to HIGH, ramp to 100, constant high PWM
      press(); check("t1_low",  bus.speed_led, 4'b0010);
      press(); check("t1_mid",  bus.speed_led, 4'b0100);
      press(); check("t1_high", bus.speed_led, 4'b1000);
      wait_duty(100, 1000);
      hi = 0;
      for (int i = 0; i < 100; i++) begin tick(); hi += int'(bus.pwm_out); end
      check("t1_pwm100", hi, 100);
      check("t1_run", bus.run, 1'b1);

      // 2: LOW settles at 30 % duty, then button-OFF ramps down
      press(); press();
      check("t2_low", bus.speed_led, 4'b0010);
      wait_duty(30, 2000);
      hi = 0;
      for (int i = 0; i < 100; i++) begin tick(); hi += int'(bus.pwm_out); end
      check("t2_pwm30", hi, 30);
      press(); press(); press();
      check("t2_off", bus.speed_led, 4'b0001);
      check("t2_run_still", bus.run, 1'b1);
      wait_duty(0, 1000);
      tick(); tick();
      check("t2_run0", bus.run, 1'b0);

      // 3: timeout at HIGH, then lockout
      press(); press(); press();
      for (int i = 0; i < 40; i++) tick();
      bus.timer_start = 1'b1; bus.timer_value = 16'h0130; tick();
      bus.start_stop = 1'b1; tick();
      check("t3_led", bus.speed_led, 4'b0001);
      check("t3_pwm", bus.pwm_out, 1'b0);
      check("t3_run", bus.run, 1'b0);
      press(); press();
      check("t3_lock", bus.speed_led, 4'b0001);
      bus.start_stop = 1'b0; tick();
      press();
      check("t3_unlock", bus.speed_led, 4'b0010);

      // 4: timeout and button edge in the same cycle at MID
      press();
      for (int i = 0; i < 20; i++) tick();
      bus.btn_speed = 1'b1; bus.start_stop = 1'b1; tick();
      check("t4_led", bus.speed_led, 4'b0001);
      check("t4_pwm", bus.pwm_out, 1'b0);
      bus.btn_speed = 1'b0; bus.start_stop = 1'b0; tick();
      check("t4_run", bus.run, 1'b0);

      // 5: warn blink and its qualifiers
      bus.timer_value = 16'h0009;
      for (int k = 0; k < 32; k++) begin
         tick();
         check("t5_blink", bus.warn, ((k / 8) % 2) == 0);
      end
      bus.timer_value = 16'h0010; tick(); check("t5_w10", bus.warn, 1'b0);
      bus.timer_value = 16'h0000; tick(); check("t5_w00", bus.warn, 1'b0);
      bus.timer_value = 16'h0009; bus.timer_start = 1'b0; bus.start_stop = 1'b1;
      tick(); check("t5_disarmed", bus.warn, 1'b0);
      press();
      check("t5_ignored", bus.speed_led, 4'b0010);
      bus.start_stop = 1'b0;

      // 6: asynchronous reset mid-ramp at MID
      press();
      wait_duty(45, 2000);
      #2;
      reset_p = 1'b1;
      model_reset();
      #1;
      check("t6_led",  bus.speed_led, 4'b0001);
      check("t6_pwm",  bus.pwm_out, 1'b0);
      check("t6_run",  bus.run, 1'b0);
      check("t6_warn", bus.warn, 1'b0);
      tick();
      reset_p = 1'b0;
      tick(); tick();
      press();
      check("t6_restart", bus.speed_led, 4'b0010);

      // Random phase against the model
      for (int i = 0; i < 1500; i++) begin
         bus.btn_speed = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 39) == 0) bus.timer_start = ~bus.timer_start;
         if ($urandom_range(0, 29) == 0) bus.start_stop = ~bus.start_stop;
         if ($urandom_range(0, 19) == 0) bus.timer_value = vals[$urandom_range(0, 5)];
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
